// File: rtl/grf_writeback_pkg.sv
// Shared constants, enums and decode payload for the W-stage writeback / GRF block.
package grf_writeback_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    localparam logic [DW-1:0] RESET_VAL = 32'h0000_0000;
    localparam logic [AW-1:0] LINK_REG  = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    // R-type function codes
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    // COP0 rs field selecting a move-from
    localparam logic [4:0] RS_MFC0 = 5'b00000;

    typedef enum logic [2:0] {
        SRC_AO  = 3'd0,
        SRC_DR  = 3'd1,
        SRC_PC8 = 3'd2,
        SRC_MDO = 3'd3,
        SRC_CP0 = 3'd4
    } src_sel_e;

    typedef enum logic [2:0] {
        LD_WORD = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4
    } load_kind_e;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] dest;
        src_sel_e      src;
        load_kind_e    kind;
    } wb_ctrl_t;

endpackage

// File: rtl/grf_writeback_if.sv
// W-stage bundle in, D-stage read ports and resolved write out.
interface grf_writeback_if;
    import grf_writeback_pkg::*;

    logic [DW-1:0] IR_W;
    logic [DW-1:0] PC8_W;
    logic [DW-1:0] AO_W;
    logic [DW-1:0] MDO_W;
    logic [DW-1:0] DR_W;
    logic [DW-1:0] CP0_W;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic [AW-1:0] A3_W;
    logic [DW-1:0] WD_W;
    logic          WE_W;

    modport master (
        output IR_W, PC8_W, AO_W, MDO_W, DR_W, CP0_W, A1, A2,
        input  RD1, RD2, A3_W, WD_W, WE_W
    );

    modport slave (
        input  IR_W, PC8_W, AO_W, MDO_W, DR_W, CP0_W, A1, A2,
        output RD1, RD2, A3_W, WD_W, WE_W
    );

endinterface

// File: rtl/grf_writeback_load_ext.sv
// Sub-word load lane select and sign/zero extension (combinational).
module grf_writeback_load_ext
    import grf_writeback_pkg::*;
(
    input  logic [DW-1:0] dr,
    input  logic [1:0]    addr_lo,
    input  load_kind_e    kind,
    output logic [DW-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half lane, then extend per load kind
    always_comb begin
        byte_sel = dr[7:0];
        case (addr_lo)
            2'd0:    byte_sel = dr[7:0];
            2'd1:    byte_sel = dr[15:8];
            2'd2:    byte_sel = dr[23:16];
            default: byte_sel = dr[31:24];
        endcase
        half_sel = addr_lo[1] ? dr[31:16] : dr[15:0];

        data_c = dr;
        case (kind)
            LD_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_c = {24'h0, byte_sel};
            LD_H:    data_c = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_c = {16'h0, half_sel};
            default: data_c = dr;
        endcase
    end

endmodule

// File: rtl/grf_writeback.sv
// W-stage writeback decode plus 32x32 general register file.
// Optional same-cycle W-to-D bypass on the read ports: define GRF_BYPASS_EN.
module grf_writeback
    import grf_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    grf_writeback_if.slave   bus
);

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          unused_shamt;
    wb_ctrl_t      ctrl;
    logic [DW-1:0] ext_data;
    logic [DW-1:0] wd;
    logic [AW-1:0] a3;
    logic          we;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] regs [NREG];

    assign op           = bus.IR_W[31:26];
    assign rs           = bus.IR_W[25:21];
    assign rt           = bus.IR_W[20:16];
    assign rd           = bus.IR_W[15:11];
    assign funct        = bus.IR_W[5:0];
    assign unused_shamt = ^bus.IR_W[10:6];

    // Decode destination, data source and load kind from the W instruction
    always_comb begin
        ctrl.wr   = 1'b0;
        ctrl.dest = '0;
        ctrl.src  = SRC_AO;
        ctrl.kind = LD_WORD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU, FUNCT_SUBU, FUNCT_ADD, FUNCT_SUB,
                    FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
                    FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL,
                    FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: begin
                        ctrl.wr   = 1'b1;
                        ctrl.dest = rd;
                    end
                    FUNCT_JALR: begin
                        ctrl.wr   = 1'b1;
                        ctrl.dest = rd;
                        ctrl.src  = SRC_PC8;
                    end
                    FUNCT_MFHI, FUNCT_MFLO: begin
                        ctrl.wr   = 1'b1;
                        ctrl.dest = rd;
                        ctrl.src  = SRC_MDO;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
                ctrl.wr   = 1'b1;
                ctrl.dest = rt;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                ctrl.wr   = 1'b1;
                ctrl.dest = rt;
                ctrl.src  = SRC_DR;
                case (op)
                    OP_LB:   ctrl.kind = LD_B;
                    OP_LBU:  ctrl.kind = LD_BU;
                    OP_LH:   ctrl.kind = LD_H;
                    OP_LHU:  ctrl.kind = LD_HU;
                    default: ctrl.kind = LD_WORD;
                endcase
            end
            OP_JAL: begin
                ctrl.wr   = 1'b1;
                ctrl.dest = LINK_REG;
                ctrl.src  = SRC_PC8;
            end
            OP_COP0: begin
                if (rs == RS_MFC0) begin
                    ctrl.wr   = 1'b1;
                    ctrl.dest = rt;
                    ctrl.src  = SRC_CP0;
                end
            end
            default: ;
        endcase
    end

    grf_writeback_load_ext u_load_ext (
        .dr      (bus.DR_W),
        .addr_lo (bus.AO_W[1:0]),
        .kind    (ctrl.kind),
        .data_c  (ext_data)
    );

    // Write-data source mux; valid even when no write is requested
    always_comb begin
        wd = bus.AO_W;
        case (ctrl.src)
            SRC_DR:  wd = ext_data;
            SRC_PC8: wd = bus.PC8_W;
            SRC_MDO: wd = bus.MDO_W;
            SRC_CP0: wd = bus.CP0_W;
            default: wd = bus.AO_W;
        endcase
    end

    assign a3 = ctrl.wr ? ctrl.dest : '0;
    assign we = (a3 != '0);

    // Register file commit; reset overrides any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (we) begin
            regs[a3] <= wd;
        end
    end

    // Combinational read ports; index 0 always reads as zero
    always_comb begin
        rd1 = (bus.A1 == '0) ? '0 : regs[bus.A1];
        rd2 = (bus.A2 == '0) ? '0 : regs[bus.A2];
`ifdef GRF_BYPASS_EN
        if (we && (bus.A1 == a3) && (bus.A1 != '0)) rd1 = wd;
        if (we && (bus.A2 == a3) && (bus.A2 != '0)) rd2 = wd;
`endif
    end

    assign bus.RD1  = rd1;
    assign bus.RD2  = rd2;
    assign bus.A3_W = a3;
    assign bus.WD_W = wd;
    assign bus.WE_W = we;

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- Consumer end of the MEM/WB pipeline register: takes the W-stage bundle and resolves destination register, write-data source and load extension.
- Commits the result into a 32x32 general register file.
- Serves the two combinational read ports used by the D stage.
- Exports the resolved W-stage write (A3/WD/WE) to the hazard and forwarding unit.

Parameters:
- NREG, 32, number of architectural registers. Fixed at 32; index width 5.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears the register file.
- IR_W  in  32  instruction in W stage. 0 denotes a bubble.
- PC8_W  in  32  PC+8 of the W instruction (link value).
- AO_W  in  32  ALU result / memory address.
- MDO_W  in  32  HI/LO read value.
- DR_W  in  32  raw word read from data memory.
- CP0_W  in  32  CP0 read value.
- A1  in  5  read port 1 index (rs).
- A2  in  5  read port 2 index (rt).
- RD1  out  32  read data for A1.
- RD2  out  32  read data for A2.
- A3_W  out  5  resolved destination index. 0 when there is no write.
- WD_W  out  32  resolved write data.
- WE_W  out  1  asserted when A3_W != 0 and the instruction writes a register.

Behaviour:
- Decode (combinational, from IR_W):
  - op=000000, funct in {addu, subu, add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav}: dest rd, data AO_W.
  - op=000000, funct=jalr: dest rd, data PC8_W.
  - op=000000, funct in {mfhi, mflo}: dest rd, data MDO_W.
  - I-type ALU (addi, addiu, andi, ori, xori, lui, slti, sltiu): dest rt, data AO_W.
  - lw: dest rt, data DR_W.
  - lb/lbu: dest rt. Byte is selected by AO_W[1:0] (0 = DR_W[7:0] ... 3 = DR_W[31:24]), then sign- or zero-extended.
  - lh/lhu: dest rt. Half is selected by AO_W[1] (0 = [15:0], 1 = [31:16]), then sign- or zero-extended.
  - jal: dest 31, data PC8_W.
  - mfc0 (op=010000, rs=00000): dest rt, data CP0_W.
  - All others (stores, branches, jr, mult, mthi, mtc0, eret, bubble): no write, A3_W=0, WE_W=0.
  - When no write occurs, WD_W still reflects the selected source; consumers must use WE_W.
- Commit: at posedge clk, if reset, all registers take RESET_VAL. Else, if WE_W, reg[A3_W] takes WD_W. Reset wins over a simultaneous write.
- Register 0:
  - Never written.
  - RD1/RD2 return 0 whenever their index is 0, regardless of array contents.
- Reads are combinational from the array. Latency of a write to visibility is 1 cycle, unless the optional bypass is enabled.
- Reset mid-operation: the instruction in W during the reset cycle is discarded; its write is lost.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: RD1 = WD_W when WE_W && A1==A3_W && A1!=0. RD2 likewise. The same-cycle read observes the pending write, removing the W-to-D forwarding path.
- Undefined: RD1/RD2 return the stored array value only. The external forwarding unit must cover the W-to-D case.

Decomposition:
- Shared package: opcode/funct constants (OP_RTYPE, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, OP_COP0, FUNCT_JALR, FUNCT_MFHI, etc.), a source-select enum (SRC_AO, SRC_DR, SRC_PC8, SRC_MDO, SRC_CP0), and a load-kind enum.
- One natural sub-module: load_ext. It is combinational: it takes DR_W, AO_W[1:0] and the load kind, and produces the extended word.

Test Plan:
- reset=1 for 1 cycle, then read A1=5, A2=31 -> RD1=RD2=0. Release reset, commit ori $5,$0,0x1234 (AO_W=0x1234) -> next cycle RD1=0x0000_1234.
- lb $8 with DR_W=0x80FF_7F01, AO_W[1:0]=3 -> reg8=0xFFFF_FF80. lbu, same inputs -> 0x0000_0080. lh with AO_W[1]=1 -> 0xFFFF_80FF.
- jal with PC8_W=0x0000_3008 -> A3_W=31, WE_W=1; next cycle RD2(A2=31)=0x0000_3008.
- addu with rd=0, AO_W=0xDEAD_BEEF -> WE_W=0; RD1(A1=0)=0 on the following cycle.
- Write $9=0x55 with A1=9 in the same cycle:
  - GRF_BYPASS_EN defined -> RD1=0x55 in that cycle.
  - GRF_BYPASS_EN undefined -> RD1 holds the old value, then 0x55 next cycle.
- Assert reset in the same cycle as lw $4 (DR_W=0x1111_1111) -> reg4=0 afterwards. Store/bubble IR_W=0 -> no register changes.
